// File: rtl/tdc_meas_arbiter_if.sv
// Measurement-in / UART-out bus of the TDC measurement arbiter.
// The arbiter is the master: it consumes measurements and drives the UART start.
interface tdc_meas_arbiter_if #(
    parameter int NCH = 4,
    parameter int MW  = 40
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*MW-1:0]  meas_data;
    logic [NCH-1:0]     meas_valid;
    logic               tx_busy;
    logic [CHW+MW-1:0]  tx_data;
    logic               tx_start;

    modport master (
        input  meas_data,
        input  meas_valid,
        input  tx_busy,
        output tx_data,
        output tx_start
    );

    modport slave (
        output meas_data,
        output meas_valid,
        output tx_busy,
        input  tx_data,
        input  tx_start
    );
endinterface

// File: rtl/tdc_meas_arbiter.sv
// Per-channel measurement FIFOs feeding one UART transmitter in round-robin order.
// Each outgoing word is {channel index, measurement}; full FIFOs drop and count.
module tdc_meas_arbiter #(
    parameter int NCH     = 4,
    parameter int MW      = 40,
    parameter int DEPTH   = 4,
    parameter int DROP_CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    tdc_meas_arbiter_if.master     bus,
    input  logic                   clear_ovf,
    output logic [NCH-1:0]         pending,
    output logic [NCH-1:0]         overflow,
    output logic [NCH*DROP_CW-1:0] drop_count
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
    localparam logic [DROP_CW-1:0] DROP_MAX = '1;
    localparam logic [DROP_CW-1:0] DROP_ONE = DROP_CW'(1);
    localparam logic [CHW:0]       NCH_W    = (CHW+1)'(NCH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic [MW-1:0]     mem_r      [NCH][DEPTH];
    logic [AW-1:0]     wr_ptr_r   [NCH];
    logic [AW-1:0]     rd_ptr_r   [NCH];
    logic [CW-1:0]     cnt_r      [NCH];
    logic [CW-1:0]     cnt_next_s [NCH];
    logic [NCH-1:0]    push_s, pop_s, drop_s;
    logic [CHW-1:0]    last_grant_r, grant_s;
    logic [CHW:0]      sum_s, idx_s;
    logic              grant_vld_s;
    logic [MW-1:0]     head_s;
    logic              tx_start_r;
    logic [CHW+MW-1:0] tx_data_r;

    // Round-robin search: scanning from the far end down lets the nearest pending channel win.
    always_comb begin
        grant_s = last_grant_r;
        sum_s   = '0;
        idx_s   = '0;
        for (int k = NCH; k >= 1; k--) begin
            sum_s   = {1'b0, last_grant_r} + (CHW+1)'(k);
            idx_s   = (sum_s >= NCH_W) ? (sum_s - NCH_W) : sum_s;
            grant_s = pending[idx_s[CHW-1:0]] ? idx_s[CHW-1:0] : grant_s;
        end
        grant_vld_s = (state_r == ST_IDLE) && !bus.tx_busy && (|pending);
        head_s      = mem_r[grant_s][rd_ptr_r[grant_s]];
    end

    // Per-channel push/pop/drop decisions; a pop frees the slot a same-cycle push needs.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pop_s[i]  = grant_vld_s && (grant_s == CHW'(i));
            push_s[i] = bus.meas_valid[i] && ((cnt_r[i] != FULL_CNT) || pop_s[i]);
            drop_s[i] = bus.meas_valid[i] && (cnt_r[i] == FULL_CNT) && !pop_s[i];
            case ({push_s[i], pop_s[i]})
                2'b10:   cnt_next_s[i] = cnt_r[i] + 1'b1;
                2'b01:   cnt_next_s[i] = cnt_r[i] - 1'b1;
                default: cnt_next_s[i] = cnt_r[i];
            endcase
        end
    end

    // Arbiter next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) state_s = ST_WAIT_ACK;
                else             state_s = ST_IDLE;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) state_s = ST_WAIT_DONE;
                else             state_s = ST_WAIT_ACK;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) state_s = ST_IDLE;
                else              state_s = ST_WAIT_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Grant outputs; tx_data holds until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start_r   <= 1'b0;
            tx_data_r    <= '0;
            last_grant_r <= CHW'(NCH - 1);
        end else begin
            tx_start_r <= grant_vld_s;
            if (grant_vld_s) begin
                tx_data_r    <= {grant_s, head_s};
                last_grant_r <= grant_s;
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push_s[i]) mem_r[i][wr_ptr_r[i]] <= bus.meas_data[i*MW +: MW];
        end
    end

    // FIFO pointers, fill level and drop bookkeeping; a drop beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
            pending    <= '0;
            overflow   <= '0;
            drop_count <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + 1'b1;
                if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + 1'b1;
                cnt_r[i]   <= cnt_next_s[i];
                pending[i] <= (cnt_next_s[i] != '0);
                if (drop_s[i]) begin
                    overflow[i] <= 1'b1;
                    if (clear_ovf)
                        drop_count[i*DROP_CW +: DROP_CW] <= DROP_ONE;
                    else if (drop_count[i*DROP_CW +: DROP_CW] != DROP_MAX)
                        drop_count[i*DROP_CW +: DROP_CW] <= drop_count[i*DROP_CW +: DROP_CW] + 1'b1;
                end else if (clear_ovf) begin
                    overflow[i]                      <= 1'b0;
                    drop_count[i*DROP_CW +: DROP_CW] <= '0;
                end
            end
        end
    end

    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
endmodule

// File: tb/tb_tdc_meas_arbiter.sv
// Directed bench for tdc_meas_arbiter: UART busy model, send monitor and
// hand-computed expectations for send order, timing, overflow and reset.
module tb_tdc_meas_arbiter;
    localparam int NCH      = 4;
    localparam int MW       = 40;
    localparam int DEPTH    = 4;
    localparam int DROP_CW  = 8;
    localparam int CHW      = 2;
    localparam int BUSY_LEN = 20;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear_ovf;
    logic [NCH-1:0]         pending;
    logic [NCH-1:0]         overflow;
    logic [NCH*DROP_CW-1:0] drop_count;
    logic                   hold_busy;
    int                     busy_cnt = 0;
    int                     cyc = 0;
    int                     n_checks = 0;
    int                     n_fail = 0;
    logic [CHW+MW-1:0]      sent_q[$];
    int                     sent_cyc_q[$];

    tdc_meas_arbiter_if #(.NCH(NCH), .MW(MW)) bus();

    tdc_meas_arbiter #(.NCH(NCH), .MW(MW), .DEPTH(DEPTH), .DROP_CW(DROP_CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clear_ovf  (clear_ovf),
        .pending    (pending),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // UART model: busy the cycle after start, for BUSY_LEN cycles, or while held.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        busy_cnt <= bus.tx_start ? BUSY_LEN : ((busy_cnt > 0) ? busy_cnt - 1 : 0);
    end
    assign bus.tx_busy = hold_busy | (busy_cnt != 0);

    // Record every start pulse with its word and cycle.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            sent_q.push_back(bus.tx_data);
            sent_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input int ch, input logic [MW-1:0] val);
        bus.meas_data[ch*MW +: MW] = val;
    endtask

    task automatic pulse(input logic [NCH-1:0] mask);
        bus.meas_valid = mask;
        tick();
        bus.meas_valid = '0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        hold_busy      = 1'b0;
        clear_ovf      = 1'b0;
        bus.meas_valid = '0;
        tick(2);
        rst = 1'b0;
        tick();
        sent_q.delete();
        sent_cyc_q.delete();
    endtask

    task automatic wait_sends(input string tag, input int n, input int budget);
        int t = 0;
        while (sent_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, 64'(sent_q.size()), 64'(n));
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((bus.tx_busy || pending != '0) && t < 400) begin
            tick();
            t++;
        end
        check(tag, {63'd0, bus.tx_busy}, 64'd0);
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        hold_busy      = 1'b0;
        clear_ovf      = 1'b0;
        bus.meas_valid = '0;
        bus.meas_data  = '0;
        tick(3);
        check("rst_tx_start",   {63'd0, bus.tx_start}, 64'd0);
        check("rst_tx_data",    64'(bus.tx_data), 64'd0);
        check("rst_pending",    64'(pending), 64'd0);
        check("rst_overflow",   64'(overflow), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        tick();

        // Single send on channel 2: start two cycles after valid.
        set_word(2, 40'h00_0000_1234);
        pulse(4'b0100);
        check("single_pend_c1",  64'(pending), 64'h4);
        check("single_start_c1", {63'd0, bus.tx_start}, 64'd0);
        tick();
        check("single_start_c2", {63'd0, bus.tx_start}, 64'd1);
        check("single_data",     64'(bus.tx_data), 64'({2'd2, 40'h00_0000_1234}));
        check("single_pend_c2",  64'(pending), 64'd0);
        tick();
        check("single_pulse_1c", {63'd0, bus.tx_start}, 64'd0);
        drain("single_drain");
        check("single_hold",     64'(bus.tx_data), 64'({2'd2, 40'h00_0000_1234}));

        // Round-robin from reset: 0, 1, 3; then 0, 3.
        do_reset();
        set_word(0, 40'd10);
        set_word(1, 40'd11);
        set_word(3, 40'd13);
        pulse(4'b1011);
        wait_sends("rr_count_a", 3, 300);
        check("rr_a0", 64'(sent_q[0]), 64'({2'd0, 40'd10}));
        check("rr_a1", 64'(sent_q[1]), 64'({2'd1, 40'd11}));
        check("rr_a2", 64'(sent_q[2]), 64'({2'd3, 40'd13}));
        check("rr_spacing", 64'(sent_cyc_q[1] - sent_cyc_q[0]), 64'(BUSY_LEN + 3));
        drain("rr_drain_a");
        sent_q.delete();
        set_word(0, 40'd20);
        set_word(3, 40'd23);
        pulse(4'b1001);
        wait_sends("rr_count_b", 2, 300);
        check("rr_b0", 64'(sent_q[0]), 64'({2'd0, 40'd20}));
        check("rr_b1", 64'(sent_q[1]), 64'({2'd3, 40'd23}));
        drain("rr_drain_b");

        // Overflow on channel 1 with UART held busy.
        do_reset();
        hold_busy = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            set_word(1, 40'(v));
            bus.meas_valid = 4'b0010;
            tick();
        end
        bus.meas_valid = '0;
        tick();
        check("ovf_flag",  64'(overflow), 64'h2);
        check("ovf_count", 64'(drop_count), 64'h0000_0200);
        check("ovf_pend",  64'(pending), 64'h2);
        check("ovf_nosend", 64'(sent_q.size()), 64'd0);
        // Channel 2: one drop, then a second drop together with clear -> drop wins.
        for (int v = 1; v <= 5; v++) begin
            set_word(2, 40'(v));
            pulse(4'b0100);
        end
        check("ovf2_count", 64'(drop_count), 64'h0001_0200);
        set_word(2, 40'd6);
        clear_ovf = 1'b1;
        pulse(4'b0100);
        clear_ovf = 1'b0;
        check("clr_drop_wins_flag",  64'(overflow), 64'h4);
        check("clr_drop_wins_count", 64'(drop_count), 64'h0001_0000);
        hold_busy = 1'b0;
        wait_sends("ovf_sends", 8, 600);
        for (int k = 0; k < 4; k++) begin
            check("ovf_ch1_order", 64'(sent_q[2*k]),   64'({2'd1, 40'(k + 1)}));
            check("ovf_ch2_order", 64'(sent_q[2*k+1]), 64'({2'd2, 40'(k + 1)}));
        end
        drain("ovf_drain");
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clr_flag",  64'(overflow), 64'd0);
        check("clr_count", 64'(drop_count), 64'd0);

        // Full FIFO 0: push in the grant cycle must not drop.
        do_reset();
        hold_busy = 1'b1;
        for (int v = 51; v <= 54; v++) begin
            set_word(0, 40'(v));
            pulse(4'b0001);
        end
        hold_busy = 1'b0;
        set_word(0, 40'd99);
        pulse(4'b0001);
        check("full_start", {63'd0, bus.tx_start}, 64'd1);
        check("full_head",  64'(bus.tx_data), 64'({2'd0, 40'd51}));
        check("full_noovf", 64'(overflow), 64'd0);
        check("full_pend",  64'(pending), 64'h1);
        wait_sends("full_sends", 5, 600);
        check("full_s3",   64'(sent_q[3]), 64'({2'd0, 40'd54}));
        check("full_last", 64'(sent_q[4]), 64'({2'd0, 40'd99}));
        check("full_nodrop", 64'(drop_count), 64'd0);
        drain("full_drain");

        // Reset while waiting for the UART to finish, with 3 words still queued.
        do_reset();
        set_word(0, 40'd1);
        set_word(1, 40'd2);
        set_word(2, 40'd3);
        set_word(3, 40'd4);
        pulse(4'b1111);
        tick();
        check("mid_first_start", {63'd0, bus.tx_start}, 64'd1);
        tick(3);
        check("mid_busy", {63'd0, bus.tx_busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_pend",  64'(pending), 64'd0);
        check("mid_start", {63'd0, bus.tx_start}, 64'd0);
        tick(40);
        check("mid_no_more", 64'(sent_q.size()), 64'd1);
        set_word(1, 40'd77);
        pulse(4'b0010);
        tick();
        check("mid_new_start", {63'd0, bus.tx_start}, 64'd1);
        check("mid_new_data",  64'(bus.tx_data), 64'({2'd1, 40'd77}));
        drain("mid_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
